// File: rtl/ternary_hazard_ctrl_if.sv
// ternary_hazard_ctrl_if: pipeline hazard bus between the ID/EX datapath and the hazard controller.
interface ternary_hazard_ctrl_if;
   logic [5:0] id_rs1;
   logic [5:0] id_rs2;
   logic       id_use_rs1;
   logic       id_use_rs2;
   logic [5:0] ex_rd;
   logic       ex_mem_read;
   logic       branch_taken;
   logic       mul_start;
   logic       mul_done;
   logic       pc_stall;
   logic       if_id_stall;
   logic       if_id_flush;
   logic       id_ex_bubble;
   logic       ex_hold;
   logic [1:0] state;
   modport master (
      output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
             branch_taken, mul_start, mul_done,
      input  pc_stall, if_id_stall, if_id_flush, id_ex_bubble, ex_hold, state
   );
   modport slave (
      input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
             branch_taken, mul_start, mul_done,
      output pc_stall, if_id_stall, if_id_flush, id_ex_bubble, ex_hold, state
   );
endinterface

// File: rtl/ternary_hazard_ctrl.sv
// ternary_hazard_ctrl: load-use / branch-flush / multi-cycle stall controller for a 3-trit-register pipeline.
// Optional performance counters enabled by defining TERNARY_HAZARD_PERFCNT_EN.
`ifndef T_ZERO
`define T_ZERO 2'b00
`endif
module ternary_hazard_ctrl (
   input  logic                    clk,
   input  logic                    rst,
`ifdef TERNARY_HAZARD_PERFCNT_EN
   output logic [15:0]             stall_cycles,
   output logic [15:0]             flush_count,
`endif
   ternary_hazard_ctrl_if.slave    bus
);
   typedef enum logic [1:0] {RUN = 2'b00, MUL_WAIT = 2'b01, FLUSH = 2'b10} state_t;
   state_t state_q, state_d;
   logic   rd_is_r0, rs1_hit, rs2_hit, load_use;
   logic   pc_stall, if_id_stall, if_id_flush, id_ex_bubble, ex_hold;
   function automatic logic trit_eq(input logic [5:0] a, input logic [5:0] b);
      return (a[1:0] == b[1:0]) && (a[3:2] == b[3:2]) && (a[5:4] == b[5:4]);
   endfunction
   assign rd_is_r0 = trit_eq(bus.ex_rd, {`T_ZERO, `T_ZERO, `T_ZERO});
   assign rs1_hit  = bus.id_use_rs1 && trit_eq(bus.id_rs1, bus.ex_rd);
   assign rs2_hit  = bus.id_use_rs2 && trit_eq(bus.id_rs2, bus.ex_rd);
   assign load_use = bus.ex_mem_read && !rd_is_r0 && (rs1_hit || rs2_hit);
   always_comb begin
      state_d      = state_q;
      pc_stall     = 1'b0;
      if_id_stall  = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_bubble = 1'b0;
      ex_hold      = 1'b0;
      case (state_q)
         MUL_WAIT: begin
            pc_stall    = !bus.mul_done;
            if_id_stall = !bus.mul_done;
            ex_hold     = !bus.mul_done;
            state_d     = bus.mul_done ? RUN : MUL_WAIT;
         end
         FLUSH: begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            state_d      = RUN;
         end
         default: begin
            // branch outranks the multi-cycle launch, which outranks load-use
            if (bus.branch_taken) begin
               if_id_flush  = 1'b1;
               id_ex_bubble = 1'b1;
               state_d      = FLUSH;
            end else if (bus.mul_start) begin
               pc_stall    = !bus.mul_done;
               if_id_stall = !bus.mul_done;
               ex_hold     = !bus.mul_done;
               state_d     = bus.mul_done ? RUN : MUL_WAIT;
            end else begin
               pc_stall     = load_use;
               if_id_stall  = load_use;
               id_ex_bubble = load_use;
               state_d      = RUN;
            end
         end
      endcase
   end
   always_ff @(posedge clk) state_q <= rst ? RUN : state_d;
   assign bus.pc_stall     = pc_stall && !rst;
   assign bus.if_id_stall  = if_id_stall && !rst;
   assign bus.if_id_flush  = if_id_flush && !rst;
   assign bus.id_ex_bubble = id_ex_bubble && !rst;
   assign bus.ex_hold      = ex_hold && !rst;
   assign bus.state        = state_q;
`ifdef TERNARY_HAZARD_PERFCNT_EN
   logic [15:0] stall_cycles_q, stall_cycles_d, flush_count_q, flush_count_d;
   logic        flush_enter;
   assign flush_enter = (state_q != MUL_WAIT) && (state_q != FLUSH) && (state_d == FLUSH);
   always_comb begin
      stall_cycles_d = stall_cycles_q + {15'd0, bus.pc_stall && stall_cycles_q != 16'hFFFF};
      flush_count_d  = flush_count_q + {15'd0, flush_enter && flush_count_q != 16'hFFFF};
   end
   always_ff @(posedge clk) begin
      stall_cycles_q <= rst ? 16'd0 : stall_cycles_d;
      flush_count_q  <= rst ? 16'd0 : flush_count_d;
   end
   assign stall_cycles = stall_cycles_q;
   assign flush_count  = flush_count_q;
`endif
endmodule

// File: doc/ternary_hazard_ctrl.md
TERNARY_HAZARD_CTRL -- requirements
Module: ternary_hazard_ctrl

Interface
REQ-001 The block SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-002 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-003 The block SHALL have ports id_rs1 and id_rs2, input, 6 each, ID-stage source addresses (3 trits, 2 bits per trit).
REQ-004 The block SHALL have ports id_use_rs1 and id_use_rs2, input, 1 each, ID instruction actually reads that source.
REQ-005 The block SHALL have ports ex_rd (input, 6, EX destination) and ex_mem_read (input, 1, EX instruction is a load).
REQ-006 The block SHALL have ports branch_taken (input, 1, EX resolved a taken branch or jump) and mul_start (input, 1, EX launches a multi-cycle op).
REQ-007 The block SHALL have port mul_done, input, 1, multi-cycle unit result valid this cycle.
REQ-008 The block SHALL have ports pc_stall, if_id_stall, if_id_flush, id_ex_bubble and ex_hold, each output, 1, pipeline-register control.
REQ-009 The block SHALL have port state, output, 2, current FSM state (RUN=00, MUL_WAIT=01, FLUSH=10; 11 unused).

Function
REQ-010 The FSM SHALL have states RUN, MUL_WAIT and FLUSH; all outputs are combinational from state and current inputs.
REQ-011 R0 SHALL be ex_rd with all three trits equal to `T_ZERO` from ternary_defs.vh; address equality SHALL be a per-trit 2-bit compare.
REQ-012 load_use SHALL be ex_mem_read && ex_rd!=R0 && ((id_use_rs1 && id_rs1==ex_rd) || (id_use_rs2 && id_rs2==ex_rd)).
REQ-013 In RUN with branch_taken=1: if_id_flush=1 and id_ex_bubble=1; next state FLUSH. mul_start and load_use SHALL be ignored that cycle.
REQ-014 In RUN with branch_taken=0 and mul_start=1: pc_stall=if_id_stall=ex_hold=1 and id_ex_bubble=0 that cycle; next state MUL_WAIT, unless mul_done=1 that same cycle, in which case the FSM stays in RUN and all outputs are 0.
REQ-015 In RUN with branch_taken=0, mul_start=0 and load_use=1: pc_stall=if_id_stall=id_ex_bubble=1 for that single cycle; the FSM stays in RUN.
REQ-016 In RUN with no condition active, all control outputs SHALL be 0.
REQ-017 In MUL_WAIT with mul_done=0: pc_stall=if_id_stall=ex_hold=1; branch_taken, mul_start and load_use SHALL be ignored.
REQ-018 In MUL_WAIT with mul_done=1: all outputs 0; next state RUN. There is no timeout.
REQ-019 FLUSH SHALL last exactly one cycle: id_ex_bubble=1 and if_id_flush=1, all other outputs 0; next state RUN. This covers the one-cycle-late PC redirect.
REQ-020 In FLUSH, branch_taken, mul_start and load_use SHALL be ignored.
REQ-021 The unused encoding 11 SHALL behave as RUN and transition to RUN.

Reset
REQ-022 While rst=1 at a clk edge, state SHALL become RUN; this also applies mid-MUL_WAIT or mid-FLUSH, abandoning the pending operation.
REQ-023 During any cycle with rst=1, all control outputs SHALL be 0 regardless of inputs.

Configuration
REQ-024 With TERNARY_HAZARD_PERFCNT_EN defined, the block SHALL add outputs stall_cycles[15:0] and flush_count[15:0].
REQ-025 stall_cycles SHALL increment on every cycle with pc_stall=1; flush_count SHALL increment on every RUN-to-FLUSH transition.
REQ-026 Both counters SHALL saturate at 16'hFFFF and clear to 0 on rst.
REQ-027 Without TERNARY_HAZARD_PERFCNT_EN, these ports and their counters SHALL NOT exist, and all other behaviour is identical.

Verification
REQ-028 Load-use: ex_mem_read=1, ex_rd=id_rs2=non-R0 code, id_use_rs2=1 -> one cycle of pc_stall/if_id_stall/id_ex_bubble=1; state stays 00.
REQ-029 R0 / unused source: ex_rd=R0 with matching id_rs1, or a match with id_use_rs1=0 -> no stall.
REQ-030 Branch: branch_taken=1 in RUN -> cycle 0 if_id_flush=id_ex_bubble=1; cycle 1 state=10 with the same outputs; cycle 2 state=00 and all outputs 0.
REQ-031 Multi-cycle: mul_start=1, mul_done asserted 4 cycles later -> pc_stall/ex_hold=1 for 4 cycles (stall_cycles +4 with macro); outputs 0 on the done cycle.
REQ-032 Priority and reset: branch_taken=1, mul_start=1 and load_use all together -> FLUSH path only. rst=1 during MUL_WAIT -> state 00 and outputs 0 next cycle.
REQ-033 Saturation: with the macro, hold 65540 stall cycles -> stall_cycles=16'hFFFF.
